// File: rtl/mips_cpu_fetch_if.sv
// Fetch-stage signal bundle: PC unit request, Avalon-MM instruction bus,
// decoder handoff and sticky status. master = fetch stage, slave = its surroundings.
interface mips_cpu_fetch_if;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_accept;
  logic [31:0] imem_address;
  logic        imem_read;
  logic        imem_waitrequest;
  logic [31:0] imem_readdata;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        halted;
  logic        fault;

  modport master (
    input  pc_in, pc_valid, imem_waitrequest, imem_readdata, instr_ready,
    output pc_accept, imem_address, imem_read, instr_out, instr_pc, instr_valid,
           halted, fault
  );

  modport slave (
    output pc_in, pc_valid, imem_waitrequest, imem_readdata, instr_ready,
    input  pc_accept, imem_address, imem_read, instr_out, instr_pc, instr_valid,
           halted, fault
  );
endinterface

// File: rtl/mips_cpu_fetch.sv
// Instruction fetch stage: one Avalon-MM word read per PC, held until the decoder takes it.
// Optional misaligned-PC fault when FETCH_ALIGN_CHECK_EN is defined.
module mips_cpu_fetch #(
  parameter logic [31:0] HALT_ADDR      = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic              clk,
  input logic              reset,
  mips_cpu_fetch_if.master bus
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  // Last counter value before the wait that trips the timeout.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_HOLD,
    ST_HALTED,
    ST_FAULT
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic             read_q, read_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      ipc_q, ipc_d;
  logic             ivalid_q, ivalid_d;
  logic             halted_q, halted_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pc_accept_c;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      read_q   <= 1'b0;
      instr_q  <= '0;
      ipc_q    <= '0;
      ivalid_q <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      read_q   <= read_d;
      instr_q  <= instr_d;
      ipc_q    <= ipc_d;
      ivalid_q <= ivalid_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    read_d      = read_q;
    instr_d     = instr_q;
    ipc_d       = ipc_q;
    ivalid_d    = ivalid_q;
    halted_d    = halted_q;
    fault_d     = fault_q;
    cnt_d       = cnt_q;
    pc_accept_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        pc_accept_c = bus.pc_valid;
        if (bus.pc_valid) begin
          if (bus.pc_in == HALT_ADDR) begin
            halted_d = 1'b1;
            state_d  = ST_HALTED;
          end
`ifdef FETCH_ALIGN_CHECK_EN
          else if (bus.pc_in[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = ST_FAULT;
          end
`endif
          else begin
            addr_d  = {bus.pc_in[31:2], 2'b00};
            read_d  = 1'b1;
            ipc_d   = bus.pc_in;
            cnt_d   = '0;
            state_d = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        if (!bus.imem_waitrequest) begin
          instr_d  = bus.imem_readdata;
          read_d   = 1'b0;
          ivalid_d = 1'b1;
          state_d  = ST_HOLD;
        end else begin
          if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (TIMEOUT_EN && (cnt_q == TIMEOUT_LAST)) begin
            read_d  = 1'b0;
            fault_d = 1'b1;
            state_d = ST_FAULT;
          end
        end
      end

      ST_HOLD: begin
        if (bus.instr_ready) begin
          ivalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end

      ST_HALTED, ST_FAULT: begin
        read_d   = 1'b0;
        ivalid_d = 1'b0;
      end

      default: begin
        read_d   = 1'b0;
        ivalid_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  assign bus.pc_accept    = pc_accept_c;
  assign bus.imem_address = addr_q;
  assign bus.imem_read    = read_q;
  assign bus.instr_out    = instr_q;
  assign bus.instr_pc     = ipc_q;
  assign bus.instr_valid  = ivalid_q;
  assign bus.halted       = halted_q;
  assign bus.fault        = fault_q;

endmodule

// File: tb/tb_mips_cpu_fetch.sv
// Directed bench for mips_cpu_fetch: table of fetch transactions plus hand-written
// halt, timeout, reset-abort and misalignment sequences.
module tb_mips_cpu_fetch;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_cpu_fetch_if bus_if ();

  mips_cpu_fetch #(
    .HALT_ADDR      (32'h0000_0000),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rdata;
    int unsigned n_wait;
    int unsigned n_hold;
    logic [31:0] exp_addr;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus_if.pc_valid = 1'b0;
    bus_if.imem_waitrequest = 1'b0;
    bus_if.instr_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    bus_if.pc_in = v.pc;
    bus_if.pc_valid = 1'b1;
    bus_if.imem_waitrequest = (v.n_wait != 0);
    bus_if.imem_readdata = 32'h0BAD_0BAD;
    bus_if.instr_ready = 1'b0;
    #1;
    chk("idle_pc_accept", 32'(bus_if.pc_accept), 32'd1);
    tick();
    bus_if.pc_valid = 1'b0;
    chk("req_read", 32'(bus_if.imem_read), 32'd1);
    chk("req_addr", bus_if.imem_address, v.exp_addr);
    chk("req_pc_accept", 32'(bus_if.pc_accept), 32'd0);
    for (int k = 0; k < int'(v.n_wait); k++) begin
      bus_if.imem_waitrequest = 1'b1;
      tick();
      chk("wait_read", 32'(bus_if.imem_read), 32'd1);
      chk("wait_addr", bus_if.imem_address, v.exp_addr);
      chk("wait_valid", 32'(bus_if.instr_valid), 32'd0);
    end
    bus_if.imem_waitrequest = 1'b0;
    bus_if.imem_readdata = v.rdata;
    tick();
    bus_if.imem_readdata = ~v.rdata;
    chk("cap_read", 32'(bus_if.imem_read), 32'd0);
    chk("cap_valid", 32'(bus_if.instr_valid), 32'd1);
    chk("cap_instr", bus_if.instr_out, v.exp_instr);
    chk("cap_pc", bus_if.instr_pc, v.exp_pc);
    for (int k = 0; k < int'(v.n_hold); k++) begin
      tick();
      chk("hold_valid", 32'(bus_if.instr_valid), 32'd1);
      chk("hold_instr", bus_if.instr_out, v.exp_instr);
      chk("hold_pc_accept", 32'(bus_if.pc_accept), 32'd0);
    end
    bus_if.instr_ready = 1'b1;
    tick();
    bus_if.instr_ready = 1'b0;
    chk("done_valid", 32'(bus_if.instr_valid), 32'd0);
  endtask

  vec_t vecs[3];

  initial begin
    vecs[0] = '{32'hBFC0_0000, 32'h2402_0005, 0, 0, 32'hBFC0_0000, 32'h2402_0005, 32'hBFC0_0000};
    vecs[1] = '{32'hBFC0_0004, 32'h8C43_0010, 3, 5, 32'hBFC0_0004, 32'h8C43_0010, 32'hBFC0_0004};
    vecs[2] = '{32'h0040_0020, 32'hDEAD_BEEF, 1, 2, 32'h0040_0020, 32'hDEAD_BEEF, 32'h0040_0020};

    bus_if.pc_in = '0;
    bus_if.pc_valid = 1'b0;
    bus_if.imem_waitrequest = 1'b0;
    bus_if.imem_readdata = '0;
    bus_if.instr_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    chk("rst_read", 32'(bus_if.imem_read), 32'd0);
    chk("rst_addr", bus_if.imem_address, 32'h0);
    chk("rst_instr", bus_if.instr_out, 32'h0);
    chk("rst_ipc", bus_if.instr_pc, 32'h0);
    chk("rst_valid", 32'(bus_if.instr_valid), 32'd0);
    chk("rst_halted", 32'(bus_if.halted), 32'd0);
    chk("rst_fault", 32'(bus_if.fault), 32'd0);
    chk("rst_pc_accept", 32'(bus_if.pc_accept), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 3; i++) run_vec(vecs[i]);

    // Halt: fetch of HALT_ADDR never touches the bus.
    bus_if.pc_in = 32'h0000_0000;
    bus_if.pc_valid = 1'b1;
    #1;
    chk("halt_pc_accept_idle", 32'(bus_if.pc_accept), 32'd1);
    tick();
    chk("halt_halted", 32'(bus_if.halted), 32'd1);
    chk("halt_read", 32'(bus_if.imem_read), 32'd0);
    chk("halt_pc_accept", 32'(bus_if.pc_accept), 32'd0);
    bus_if.pc_in = 32'hBFC0_0000;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("halt_sticky", 32'(bus_if.halted), 32'd1);
      chk("halt_no_read", 32'(bus_if.imem_read), 32'd0);
      chk("halt_no_accept", 32'(bus_if.pc_accept), 32'd0);
    end
    do_reset();
    chk("halt_cleared", 32'(bus_if.halted), 32'd0);

    // Timeout: waitrequest stuck high with TIMEOUT_CYCLES=4.
    bus_if.pc_in = 32'h0000_1000;
    bus_if.pc_valid = 1'b1;
    bus_if.imem_waitrequest = 1'b1;
    tick();
    bus_if.pc_valid = 1'b0;
    chk("to_read_start", 32'(bus_if.imem_read), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("to_read_wait", 32'(bus_if.imem_read), 32'd1);
      chk("to_addr_wait", bus_if.imem_address, 32'h0000_1000);
      chk("to_no_fault", 32'(bus_if.fault), 32'd0);
    end
    tick();
    chk("to_fault", 32'(bus_if.fault), 32'd1);
    chk("to_read_drop", 32'(bus_if.imem_read), 32'd0);
    bus_if.pc_valid = 1'b1;
    bus_if.imem_waitrequest = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("to_fault_sticky", 32'(bus_if.fault), 32'd1);
      chk("to_no_accept", 32'(bus_if.pc_accept), 32'd0);
      chk("to_no_read", 32'(bus_if.imem_read), 32'd0);
    end
    do_reset();
    chk("to_fault_cleared", 32'(bus_if.fault), 32'd0);

    // Reset in REQ abandons the transfer; a fresh fetch then completes.
    bus_if.pc_in = 32'hBFC0_0010;
    bus_if.pc_valid = 1'b1;
    bus_if.imem_waitrequest = 1'b1;
    tick();
    bus_if.pc_valid = 1'b0;
    tick();
    chk("rreq_read_before", 32'(bus_if.imem_read), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus_if.imem_waitrequest = 1'b0;
    chk("rreq_read", 32'(bus_if.imem_read), 32'd0);
    chk("rreq_valid", 32'(bus_if.instr_valid), 32'd0);
    chk("rreq_fault", 32'(bus_if.fault), 32'd0);
    run_vec('{32'hBFC0_0014, 32'h0000_000C, 0, 1, 32'hBFC0_0014, 32'h0000_000C, 32'hBFC0_0014});

    // Misaligned PC.
`ifdef FETCH_ALIGN_CHECK_EN
    bus_if.pc_in = 32'hBFC0_0002;
    bus_if.pc_valid = 1'b1;
    #1;
    chk("mis_pc_accept", 32'(bus_if.pc_accept), 32'd1);
    tick();
    bus_if.pc_valid = 1'b0;
    chk("mis_fault", 32'(bus_if.fault), 32'd1);
    chk("mis_no_read", 32'(bus_if.imem_read), 32'd0);
    tick();
    chk("mis_no_read2", 32'(bus_if.imem_read), 32'd0);
    do_reset();
`else
    run_vec('{32'hBFC0_0002, 32'h0000_000C, 0, 1, 32'hBFC0_0000, 32'h0000_000C, 32'hBFC0_0002});
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule
